// File: rtl/dcache_resp_pkg.sv
// dcache_resp_pkg: shared FSM states, beat-index width and cache access-size codes.
package dcache_resp_pkg;
    typedef enum logic [1:0] {IDLE, LAT, RD, WR} state_t;
    localparam int BEAT_W = 2;
    localparam logic [2:0] CACHE_BYTE  = 3'd0;
    localparam logic [2:0] CACHE_HWORD = 3'd1;
    localparam logic [2:0] CACHE_WORD  = 3'd2;
endpackage

// File: rtl/dresp_strobe_gen.sv
// dresp_strobe_gen: active-low per-byte write enables from access size and byte offset.
module dresp_strobe_gen
    import dcache_resp_pkg::*;
(
    input  logic [2:0] D_type,
    input  logic [1:0] addr,
    output logic [3:0] web
);
    assign web = D_type == CACHE_BYTE  ? ~(4'b0001 << addr) :
                 D_type == CACHE_HWORD ? (addr == 2'b00 ? 4'b1100 : 4'b0011) :
                 D_type == CACHE_WORD  ? 4'b0000 : 4'b1111;
endmodule

// File: rtl/dcache_mem_responder.sv
// dcache_mem_responder: serves L1 dcache line reads (4 beats, word 3 first) and single-word
// writes against a synchronous SRAM with a fixed WAIT_CYC-cycle latency.
module dcache_mem_responder
    import dcache_resp_pkg::*;
#(
    parameter int WAIT_CYC = 2,
    parameter int MEM_AW   = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              D_req,
    input  logic [31:0]       D_addr,
    input  logic              D_write,
    input  logic [31:0]       D_in,
    input  logic [2:0]        D_type,
    output logic [31:0]       D_out,
    output logic              D_wait,
    output logic              mem_cs,
    output logic [3:0]        mem_web,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_di,
    input  logic [31:0]       mem_do
);
    state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [BEAT_W-1:0] beat, beat_n, word;
    logic [31:0] addr_q, din_q;
    logic write_q;
    logic [2:0] type_q;
    logic [MEM_AW-1:0] addr_hold, acc_addr;
    logic [31:0] di_hold;
    logic access;
    logic [3:0] strobe;

    dresp_strobe_gen u_strobe (
        .D_type(type_q),
        .addr  (addr_q[1:0]),
        .web   (strobe)
    );

    // A dropped D_req in any busy state aborts without touching memory in that cycle.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        beat_n  = beat;
        D_wait  = 1'b1;
        access  = 1'b0;
        word    = '0;
        case (state)
            IDLE: if (D_req) begin
                state_n = LAT;
                cnt_n   = 4'(WAIT_CYC);
                beat_n  = '0;
            end
            LAT: if (!D_req) state_n = IDLE;
            else begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_n = write_q ? WR : RD;
                    access  = !write_q;
                    word    = BEAT_W'(3);
                end
            end
            RD: if (!D_req) state_n = IDLE;
            else begin
                D_wait  = 1'b0;
                beat_n  = beat + 1'b1;
                state_n = beat == BEAT_W'(3) ? IDLE : RD;
                access  = beat != BEAT_W'(3);
                word    = BEAT_W'(2) - beat;
            end
            WR: begin
                state_n = IDLE;
                D_wait  = !D_req;
                access  = D_req;
            end
            default: state_n = IDLE;
        endcase
    end

    assign acc_addr = write_q ? addr_q[MEM_AW+1:2] : {addr_q[MEM_AW+1:4], word};
    assign mem_cs   = access;
    assign mem_web  = access && write_q ? strobe : 4'b1111;
    assign mem_addr = access ? acc_addr : addr_hold;
    assign mem_di   = access && write_q ? din_q : di_hold;
    assign D_out    = !D_wait && !write_q ? mem_do : 32'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            beat      <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            write_q   <= 1'b0;
            type_q    <= '0;
            addr_hold <= '0;
            di_hold   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            beat  <= beat_n;
            if (state == IDLE && D_req) begin
                addr_q  <= D_addr;
                din_q   <= D_in;
                write_q <= D_write;
                type_q  <= D_type;
            end
            if (access) begin
                addr_hold <= mem_addr;
                di_hold   <= mem_di;
            end
        end
    end
endmodule

// File: tb/tb_dcache_mem_responder.sv
// tb_dcache_mem_responder: directed vectors against a small synchronous SRAM model.
module tb_dcache_mem_responder;
    import dcache_resp_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        D_req, D_write;
    logic [31:0] D_addr, D_in, D_out;
    logic [2:0]  D_type;
    logic        D_wait, mem_cs;
    logic [3:0]  mem_web;
    logic [13:0] mem_addr;
    logic [31:0] mem_di, mem_do;

    logic [31:0] mem [0:16383];
    logic        ld = 1'b0;
    logic [13:0] ld_a = '0;
    logic [31:0] ld_d = '0;
    int          nwr = 0;
    int          checks = 0;
    int          errors = 0;

    dcache_mem_responder #(.WAIT_CYC(2), .MEM_AW(14)) dut (
        .clk(clk), .rst(rst), .D_req(D_req), .D_addr(D_addr), .D_write(D_write),
        .D_in(D_in), .D_type(D_type), .D_out(D_out), .D_wait(D_wait),
        .mem_cs(mem_cs), .mem_web(mem_web), .mem_addr(mem_addr), .mem_di(mem_di),
        .mem_do(mem_do)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld) mem[ld_a] <= ld_d;
        else if (mem_cs) begin
            for (int i = 0; i < 4; i++)
                if (!mem_web[i]) mem[mem_addr][8*i +: 8] <= mem_di[8*i +: 8];
            mem_do <= mem[mem_addr];
            if (mem_web != 4'b1111) nwr <= nwr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [13:0] a, input logic [31:0] d);
        ld = 1'b1; ld_a = a; ld_d = d;
        tick();
        ld = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t,
                      input logic [3:0] exp_web);
        D_req = 1'b1; D_write = 1'b1; D_addr = a; D_in = d; D_type = t;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("wr_wait_t%0d", c), 32'(D_wait), c == 3 ? 32'd0 : 32'd1);
            chk($sformatf("wr_cs_t%0d", c), 32'(mem_cs), c == 3 ? 32'd1 : 32'd0);
            if (c == 3) begin
                chk("wr_web", 32'(mem_web), 32'(exp_web));
                chk("wr_addr", 32'(mem_addr), 32'(a[15:2]));
                chk("wr_di", mem_di, d);
            end
            tick();
        end
        D_req = 1'b0; D_write = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e0, input logic [31:0] e1,
                      input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        D_req = 1'b1; D_write = 1'b0; D_addr = a; D_type = 3'b111;
        for (int c = 0; c < 8; c++) begin
            if (c == 7) D_req = 1'b0;
            @(negedge clk);
            chk($sformatf("rd_wait_t%0d", c), 32'(D_wait), (c >= 3 && c <= 6) ? 32'd0 : 32'd1);
            chk($sformatf("rd_out_t%0d", c), D_out, (c >= 3 && c <= 6) ? e[c-3] : 32'd0);
            if (c == 2) chk("rd_first_addr", 32'(mem_addr), 32'({a[15:4], 2'b11}));
            tick();
        end
    endtask

    initial begin
        int n0;
        rst = 1'b1; D_req = 1'b0; D_write = 1'b0; D_addr = '0; D_in = '0; D_type = '0;
        @(negedge clk);
        chk("rst_wait", 32'(D_wait), 32'd1);
        chk("rst_out", D_out, 32'd0);
        chk("rst_cs", 32'(mem_cs), 32'd0);
        chk("rst_web", 32'(mem_web), 32'hF);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_di", mem_di, 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) load(14'h40 + 14'(i), 32'hA000_00A0 + i);
        for (int i = 0; i < 4; i++) load(14'hC0 + 14'(i), 32'hB0B0_0000 + i);
        load(14'h80, 32'h1122_3344);
        load(14'h81, 32'h5566_7788);
        load(14'h82, 32'h0);
        load(14'h83, 32'h9999_9999);
        load(14'h84, 32'h0);
        load(14'h85, 32'h7777_7777);

        rd(32'h104, 32'hA000_00A3, 32'hA000_00A2, 32'hA000_00A1, 32'hA000_00A0);

        wr(32'h202, 32'h00AB_0000, CACHE_BYTE, 4'b1011);
        chk("mem_byte", mem[14'h80], 32'h11AB_3344);
        wr(32'h206, 32'hBEEF_0000, CACHE_HWORD, 4'b0011);
        chk("mem_hword", mem[14'h81], 32'hBEEF_7788);
        wr(32'h208, 32'hCAFE_F00D, CACHE_WORD, 4'b0000);
        chk("mem_word", mem[14'h82], 32'hCAFE_F00D);
        wr(32'h20C, 32'h1234_5678, 3'b111, 4'b1111);
        chk("mem_badtype", mem[14'h83], 32'h9999_9999);
        chk("nwr_after_writes", 32'(nwr), 32'd3);

        // read aborted in the last latency cycle, then a fresh write
        D_req = 1'b1; D_write = 1'b0; D_addr = 32'h104;
        tick(); tick();
        D_req = 1'b0;
        @(negedge clk);
        chk("abort_cs", 32'(mem_cs), 32'd0);
        chk("abort_wait", 32'(D_wait), 32'd1);
        tick();
        @(negedge clk);
        chk("abort_idle_cs", 32'(mem_cs), 32'd0);
        tick();
        wr(32'h210, 32'h1234_5678, CACHE_WORD, 4'b0000);
        chk("mem_after_abort", mem[14'h84], 32'h1234_5678);

        // reset during the latency of a write
        n0 = nwr;
        D_req = 1'b1; D_write = 1'b1; D_addr = 32'h214; D_in = 32'hDEAD_BEEF; D_type = CACHE_WORD;
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("mrst_cs", 32'(mem_cs), 32'd0);
        chk("mrst_web", 32'(mem_web), 32'hF);
        chk("mrst_wait", 32'(D_wait), 32'd1);
        chk("mrst_out", D_out, 32'd0);
        chk("mrst_addr", 32'(mem_addr), 32'd0);
        chk("mrst_di", mem_di, 32'd0);
        tick();
        rst = 1'b0; D_req = 1'b0; D_write = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("mrst_mem", mem[14'h85], 32'h7777_7777);
        chk("mrst_nwr", 32'(nwr - n0), 32'd0);

        // back-to-back line read then write to the same line
        n0 = nwr;
        D_req = 1'b1; D_write = 1'b0; D_addr = 32'h300;
        for (int c = 0; c < 12; c++) begin
            if (c == 7) begin D_write = 1'b1; D_in = 32'h5A5A_5A5A; D_type = CACHE_WORD; end
            if (c == 11) D_req = 1'b0;
            @(negedge clk);
            chk($sformatf("b2b_wait_t%0d", c), 32'(D_wait),
                ((c >= 3 && c <= 6) || c == 10) ? 32'd0 : 32'd1);
            if (c >= 3 && c <= 6) chk($sformatf("b2b_out_t%0d", c), D_out, 32'hB0B0_0000 + 32'(6 - c));
            if (c == 10) begin
                chk("b2b_web", 32'(mem_web), 32'h0);
                chk("b2b_addr", 32'(mem_addr), 32'hC0);
            end
            tick();
        end
        chk("b2b_nwr", 32'(nwr - n0), 32'd1);
        chk("b2b_mem", mem[14'hC0], 32'h5A5A_5A5A);
        chk("b2b_mem_nb", mem[14'hC1], 32'hB0B0_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
